// File: rtl/regfile_exec_pipe.sv
// Two-stage execute datapath: register file with operand select and EX-result bypass,
// a registered execute stage with an extended ALU, and an iterative shift-add multiplier.
module regfile_exec_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  en,
  input  logic                  ALUSrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic [3:0]            ALU_ctrl,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  eq,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int unsigned NREG     = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W    = $clog2(DATA_WIDTH);
  localparam int unsigned MUL_LAST = DATA_WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_PASS = 4'b1011;

  logic [DATA_WIDTH-1:0] regs [NREG];

  logic                  ex_valid;
  logic                  ex_en;
  logic                  ex_eq;
  logic [3:0]            ex_ctrl;
  logic [ADDR_WIDTH-1:0] ex_rd;
  logic [DATA_WIDTH-1:0] ex_op1;
  logic [DATA_WIDTH-1:0] ex_op2;
  logic [DATA_WIDTH-1:0] mul_acc;
  logic [CNT_W-1:0]      mul_cnt;

  logic                  ex_is_mul;
  logic                  mul_last;
  logic                  ex_done;
  logic                  byp_hit;
  logic                  issue;
  logic [DATA_WIDTH-1:0] mul_sum;
  logic [DATA_WIDTH-1:0] ex_result;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] rd2_val;
  logic [DATA_WIDTH-1:0] op2;
  logic [SHAMT_W-1:0]    shamt;

  assign ex_is_mul = (ex_ctrl == OP_MUL);
  assign mul_last  = (mul_cnt == CNT_W'(MUL_LAST));
  assign ex_done   = ex_valid && (!ex_is_mul || mul_last);
  assign byp_hit   = ex_done && ex_en && (ex_rd != '0);
  assign issue     = in_valid && in_ready;
  assign shamt     = ex_op2[SHAMT_W-1:0];
  // During MUL, ex_op1 is the left-shifting multiplicand and ex_op2 the right-shifting multiplier.
  assign mul_sum   = mul_acc + (ex_op2[0] ? ex_op1 : '0);
  assign a0        = regs[10];

  // Execute-stage ALU
  always_comb begin
    ex_result = '0;
    case (ex_ctrl)
      OP_ADD:  ex_result = ex_op1 + ex_op2;
      OP_SUB:  ex_result = ex_op1 - ex_op2;
      OP_AND:  ex_result = ex_op1 & ex_op2;
      OP_OR:   ex_result = ex_op1 | ex_op2;
      OP_XOR:  ex_result = ex_op1 ^ ex_op2;
      OP_SLT:  ex_result = DATA_WIDTH'($signed(ex_op1) < $signed(ex_op2));
      OP_SLTU: ex_result = DATA_WIDTH'(ex_op1 < ex_op2);
      OP_SLL:  ex_result = ex_op1 << shamt;
      OP_SRL:  ex_result = ex_op1 >> shamt;
      OP_SRA:  ex_result = DATA_WIDTH'($signed(ex_op1) >>> shamt);
      OP_MUL:  ex_result = mul_sum;
      OP_PASS: ex_result = ex_op2;
      default: ex_result = '0;
    endcase
  end

  // Register read with bypass from the retiring EX op; x0 is hardwired to zero
  always_comb begin
    op1     = '0;
    rd2_val = '0;
    if (rs1 != '0) op1 = (byp_hit && (ex_rd == rs1)) ? ex_result : regs[rs1];
    if (rs2 != '0) rd2_val = (byp_hit && (ex_rd == rs2)) ? ex_result : regs[rs2];
    op2 = ALUSrc ? ImmOp : rd2_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      ex_valid  <= 1'b0;
      ex_en     <= 1'b0;
      ex_eq     <= 1'b0;
      ex_ctrl   <= '0;
      ex_rd     <= '0;
      ex_op1    <= '0;
      ex_op2    <= '0;
      mul_acc   <= '0;
      mul_cnt   <= '0;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      eq        <= 1'b0;
    end else begin
      res_valid <= 1'b0;

      if (ex_valid && ex_is_mul && !mul_last) begin
        mul_acc <= mul_sum;
        ex_op1  <= ex_op1 << 1;
        ex_op2  <= ex_op2 >> 1;
        mul_cnt <= mul_cnt + CNT_W'(1);
      end

      if (ex_done) begin
        res_valid <= 1'b1;
        res_data  <= ex_result;
        eq        <= ex_eq;
        ex_valid  <= 1'b0;
        if (ex_en && (ex_rd != '0)) regs[ex_rd] <= ex_result;
      end

      if (issue) begin
        ex_valid <= 1'b1;
        ex_op1   <= op1;
        ex_op2   <= op2;
        ex_eq    <= (op1 == op2);
        ex_ctrl  <= ALU_ctrl;
        ex_rd    <= rd;
        ex_en    <= en;
        mul_acc  <= '0;
        mul_cnt  <= '0;
      end

      // Ready for next cycle: low while a MUL has not yet reached its final EX cycle
      if (issue && (ALU_ctrl == OP_MUL)) begin
        in_ready <= 1'b0;
      end else if (ex_valid && ex_is_mul && !mul_last) begin
        in_ready <= (mul_cnt == CNT_W'(MUL_LAST - 1));
      end else begin
        in_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_exec_pipe.sv
// Scoreboard bench for regfile_exec_pipe: an architectural register model predicts each
// retirement (data, eq, a0, cycle) and a negedge monitor checks them plus in_ready.
module tb_regfile_exec_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLT = 4'd5, SLTU = 4'd6;
  localparam logic [3:0] SLL = 4'd7, SRA = 4'd9, MUL = 4'd10;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] rs1, rs2, rd;
  logic          en;
  logic          ALUSrc;
  logic [DW-1:0] ImmOp;
  logic [3:0]    ALU_ctrl;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          eq;
  logic [DW-1:0] a0;

  regfile_exec_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .en(en), .ALUSrc(ALUSrc), .ImmOp(ImmOp),
    .ALU_ctrl(ALU_ctrl), .res_valid(res_valid), .res_data(res_data), .eq(eq), .a0(a0)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          eqv;
    logic [DW-1:0] a0v;
    int            due;
    logic          has_gold;
    logic [DW-1:0] gold;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] mregs [32];
  int            cyc = 0;
  int            busy_lo = 0;
  int            busy_hi = -1;
  int            checks = 0;
  int            errors = 0;
  logic          mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input logic [3:0] c, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return $signed(a) >>> b[4:0];
      4'd10: return a * b;
      4'd11: return b;
      default: return '0;
    endcase
  endfunction

  // Retire monitor and per-cycle ready check
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", 32'(in_ready), (cyc >= busy_lo && cyc <= busy_hi) ? 32'd0 : 32'd1);
      if (res_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_res_valid cyc=%0d got=1 expected=0", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("res_data", res_data, e.data);
          chk("eq", 32'(eq), 32'(e.eqv));
          chk("a0", a0, e.a0v);
          chk("latency", 32'(cyc), 32'(e.due));
          if (e.has_gold) chk("golden", res_data, e.gold);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic e, input logic src, input logic [DW-1:0] imm,
                       input logic [3:0] c, input logic hg, input logic [DW-1:0] g);
    int waited = 0;
    logic [DW-1:0] a, b, r;
    exp_t x;
    // While stalled, present junk requests that must be ignored
    while (!in_ready && waited < 100) begin
      in_valid = 1'b1;
      rs1 = 5'($urandom()); rs2 = 5'($urandom()); rd = 5'($urandom());
      en = 1'b1; ALUSrc = 1'($urandom()); ImmOp = $urandom(); ALU_ctrl = 4'($urandom());
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout cyc=%0d got=0 expected=1", cyc);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1; rs1 = s1; rs2 = s2; rd = d; en = e; ALUSrc = src; ImmOp = imm; ALU_ctrl = c;
    a = (s1 == 0) ? '0 : mregs[s1];
    b = src ? imm : ((s2 == 0) ? '0 : mregs[s2]);
    r = ref_alu(c, a, b);
    if (e && d != 0) mregs[d] = r;
    x.data = r; x.eqv = (a == b); x.a0v = mregs[10];
    x.due = cyc + ((c == MUL) ? DW + 1 : 2);
    x.has_gold = hg; x.gold = g;
    sbq.push_back(x);
    if (c == MUL) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + DW - 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    busy_lo = 0;
    busy_hi = -1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_eq", 32'(eq), 32'd0);
    chk("rst_a0", a0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; en = 1'b0;
    ALUSrc = 1'b0; ImmOp = '0; ALU_ctrl = '0;
    @(posedge clk); #1;
    do_reset();
    mon_en = 1'b1;

    issue(0, 0, 10, 1, 1, 32'd5, ADD, 1, 32'd5);
    issue(0, 0, 1, 1, 1, 32'd7, ADD, 1, 32'd7);
    issue(1, 1, 2, 1, 0, 32'd0, ADD, 1, 32'd14);
    issue(0, 0, 5, 1, 1, 32'd3, ADD, 1, 32'd3);
    issue(0, 0, 6, 1, 1, 32'd5, ADD, 1, 32'd5);
    issue(5, 6, 7, 1, 0, 32'd0, SUB, 1, 32'hFFFF_FFFE);
    issue(0, 0, 8, 1, 1, 32'hFFFF_FFFF, ADD, 1, 32'hFFFF_FFFF);
    issue(8, 0, 9, 1, 1, 32'd1, SLT, 1, 32'd1);
    issue(8, 0, 9, 1, 1, 32'd1, SLTU, 1, 32'd0);
    issue(0, 0, 11, 1, 1, 32'h8000_0000, ADD, 1, 32'h8000_0000);
    issue(11, 0, 12, 1, 1, 32'd4, SRA, 1, 32'hF800_0000);
    issue(1, 0, 13, 1, 1, 32'd33, SLL, 1, 32'd14);
    issue(1, 0, 15, 1, 1, 32'd7, ADD, 1, 32'd14);
    issue(0, 0, 12, 1, 1, 32'h0001_0001, ADD, 1, 32'h0001_0001);
    issue(12, 0, 3, 1, 1, 32'h10, MUL, 1, 32'h0010_0010);
    issue(3, 0, 14, 1, 0, 32'd0, ADD, 1, 32'h0010_0010);
    issue(0, 0, 0, 1, 1, 32'd9, ADD, 1, 32'd9);
    issue(0, 0, 4, 1, 0, 32'd0, ADD, 1, 32'd0);
    issue(0, 0, 10, 0, 1, 32'h77, ADD, 1, 32'h77);
    issue(10, 0, 4, 1, 0, 32'd0, ADD, 1, 32'd5);

    for (int k = 0; k < 300; k++) begin
      logic [DW-1:0] imm;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      imm = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      issue(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
            1'($urandom_range(0, 4) != 0), 1'($urandom()), imm, 4'($urandom()), 0, '0);
    end
    drain();

    // Reset ten cycles into a multiply: it must never retire
    issue(0, 0, 10, 1, 1, 32'd123, ADD, 0, '0);
    issue(10, 0, 3, 1, 1, 32'd3, MUL, 0, '0);
    repeat (9) begin @(posedge clk); #1; end
    do_reset();
    for (int k = 0; k < 32; k++) issue(5'(k), 5'(k), 0, 0, 0, 32'd0, ADD, 1, 32'd0);
    drain();
    repeat (DW + 4) begin @(posedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
